// File: rtl/traffic_sensor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor (with per-channel helper traffic_sensor_ch)
// Purpose  : Two independent loop-detector channels (NS = A, EW = B).
//            Each channel synchronises and debounces its raw loop level,
//            counts debounced arrivals into a saturating 4-bit queue, and
//            discharges one queued car per PASS cycles of its own green
//            light. Ta/Tb flag "traffic present" to the light controller.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous reset, active low
//            raw_a, raw_b - raw loop levels (async, may bounce)
//            La, Lb [1:0] - light codes: 0 green, 1 yellow, 2/3 red
//            Ta, Tb       - traffic present (registered)
//            cnt_a, cnt_b - queued-car counts [3:0] (registered)
// Params   : DEB  - debounce length in cycles, 2..15
//            PASS - green cycles per discharged car, 2..255
// Revision : 1.0 - initial release
// ============================================================================

module traffic_sensor_ch #(
  parameter int DEB  = 4,
  parameter int PASS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  input  logic [1:0] i_light,
  output logic       o_t,
  output logic [3:0] o_cnt
);

  localparam logic [3:0] c_DEB_MAX  = 4'(DEB - 1);
  localparam logic [7:0] c_PASS_MAX = 8'(PASS - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_deb;
  logic [3:0] r_dc;
  logic [7:0] r_pt;
  logic [3:0] r_cnt;
  logic       r_t;

  logic       w_mismatch;
  logic       w_flip;
  logic       w_arr;
  logic       w_run;
  logic       w_dep;
  logic       w_deb_nxt;
  logic [3:0] w_cnt_nxt;

  // deb only toggles after DEB consecutive mismatching samples of s2
  assign w_mismatch = (r_s2 != r_deb);
  assign w_flip     = w_mismatch && (r_dc == c_DEB_MAX);
  assign w_arr      = w_flip && !r_deb;

  // Pass timer only runs on our own green with something queued
  assign w_run      = (i_light == 2'd0) && (r_cnt != 4'd0);
  assign w_dep      = w_run && (r_pt == c_PASS_MAX);

  always_comb begin
    w_deb_nxt = r_deb ^ w_flip;
    w_cnt_nxt = r_cnt;
    // Simultaneous arrival and departure cancel, even at saturation
    if (w_arr && !w_dep) begin
      if (r_cnt != 4'hF) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end else if (w_dep && !w_arr) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_dc  <= 4'd0;
      r_pt  <= 8'd0;
      r_cnt <= 4'd0;
      r_t   <= 1'b0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_deb <= w_deb_nxt;
      if (!w_mismatch || w_flip) begin
        r_dc <= 4'd0;
      end else begin
        r_dc <= r_dc + 4'd1;
      end
      // Leaving green (or emptying the queue) discards the partial count
      if (w_run && !w_dep) begin
        r_pt <= r_pt + 8'd1;
      end else begin
        r_pt <= 8'd0;
      end
      r_cnt <= w_cnt_nxt;
      // Built from next-state values so T tracks deb/cnt on the same edge
      r_t   <= w_deb_nxt | (w_cnt_nxt != 4'd0);
    end
  end

  assign o_t   = r_t;
  assign o_cnt = r_cnt;

endmodule

module traffic_sensor #(
  parameter int DEB  = 4,
  parameter int PASS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tb,
  output logic [3:0] cnt_a,
  output logic [3:0] cnt_b
);

  traffic_sensor_ch #(.DEB(DEB), .PASS(PASS)) u_ch_a (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (raw_a),
    .i_light (La),
    .o_t     (Ta),
    .o_cnt   (cnt_a)
  );

  traffic_sensor_ch #(.DEB(DEB), .PASS(PASS)) u_ch_b (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (raw_b),
    .i_light (Lb),
    .o_t     (Tb),
    .o_cnt   (cnt_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_traffic_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sensor
// Purpose  : Directed self-checking bench for traffic_sensor (DEB=4, PASS=8).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================

module tb_traffic_sensor;

  logic       clk;
  logic       rst;
  logic       raw_a;
  logic       raw_b;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       Ta;
  logic       Tb;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;

  int n_checks;
  int n_errs;

  traffic_sensor #(.DEB(4), .PASS(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .La    (La),
    .Lb    (Lb),
    .Ta    (Ta),
    .Tb    (Tb),
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full car: raw held long enough to debounce high, then low again
  task automatic arrive_a();
    raw_a = 1'b1;
    tick(8);
    raw_a = 1'b0;
    tick(8);
  endtask

  task automatic arrive_b();
    raw_b = 1'b1;
    tick(8);
    raw_b = 1'b0;
    tick(8);
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst   = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    La    = 2'd2;
    Lb    = 2'd2;

    // Reset state
    tick(2);
    chk("rst_Ta", 32'(Ta), 32'd0);
    chk("rst_Tb", 32'(Tb), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    rst = 1'b1;
    tick(2);

    // Glitch rejection: 3 cycles high never debounces
    raw_a = 1'b1;
    tick(3);
    raw_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_Ta", 32'(Ta), 32'd0);
      chk("glitch_cnt_a", 32'(cnt_a), 32'd0);
    end

    // Clean arrival: Ta and cnt_a rise on the 6th edge
    raw_a = 1'b1;
    tick(5);
    chk("arr_Ta_edge5", 32'(Ta), 32'd0);
    chk("arr_cnt_edge5", 32'(cnt_a), 32'd0);
    tick(1);
    chk("arr_Ta_edge6", 32'(Ta), 32'd1);
    chk("arr_cnt_edge6", 32'(cnt_a), 32'd1);
    tick(10);
    chk("arr_hold_cnt", 32'(cnt_a), 32'd1);
    raw_a = 1'b0;
    tick(8);
    chk("arr_left_cnt", 32'(cnt_a), 32'd1);
    chk("arr_left_Ta", 32'(Ta), 32'd1);

    // Build queue to 3 under red
    arrive_a();
    arrive_a();
    chk("q3_cnt_a", 32'(cnt_a), 32'd3);

    // Discharge: one car per 8 green cycles
    La = 2'd0;
    tick(7);
    chk("dis_cnt_e7", 32'(cnt_a), 32'd3);
    tick(1);
    chk("dis_cnt_e8", 32'(cnt_a), 32'd2);
    tick(7);
    chk("dis_cnt_e15", 32'(cnt_a), 32'd2);
    tick(1);
    chk("dis_cnt_e16", 32'(cnt_a), 32'd1);
    tick(7);
    chk("dis_Ta_e23", 32'(Ta), 32'd1);
    tick(1);
    chk("dis_cnt_e24", 32'(cnt_a), 32'd0);
    chk("dis_Ta_e24", 32'(Ta), 32'd0);
    tick(10);
    chk("dis_empty_cnt", 32'(cnt_a), 32'd0);
    La = 2'd2;

    // Green interruption: partial pass count is lost
    arrive_a();
    arrive_a();
    chk("gi_cnt_start", 32'(cnt_a), 32'd2);
    La = 2'd0;
    tick(5);
    La = 2'd1;
    tick(10);
    chk("gi_cnt_yellow", 32'(cnt_a), 32'd2);
    La = 2'd0;
    tick(7);
    chk("gi_cnt_e7", 32'(cnt_a), 32'd2);
    tick(1);
    chk("gi_cnt_e8", 32'(cnt_a), 32'd1);
    tick(8);
    chk("gi_cnt_empty", 32'(cnt_a), 32'd0);
    La = 2'd2;

    // Saturation on channel B
    for (int i = 0; i < 15; i++) arrive_b();
    chk("sat_cnt_b15", 32'(cnt_b), 32'd15);
    arrive_b();
    chk("sat_cnt_b16", 32'(cnt_b), 32'd15);
    chk("sat_Tb", 32'(Tb), 32'd1);
    chk("sat_cnt_a_indep", 32'(cnt_a), 32'd0);

    // Arrival lands on the same edge as the first departure (edge 8)
    Lb = 2'd0;
    tick(2);
    raw_b = 1'b1;
    tick(5);
    chk("sim_cnt_e7", 32'(cnt_b), 32'd15);
    tick(1);
    chk("sim_cnt_e8", 32'(cnt_b), 32'd15);
    tick(7);
    chk("sim_cnt_e15", 32'(cnt_b), 32'd15);
    tick(1);
    chk("sim_cnt_e16", 32'(cnt_b), 32'd14);
    Lb    = 2'd2;
    raw_b = 1'b0;
    tick(8);

    // Async reset mid-debounce with cnt_a=4
    for (int i = 0; i < 4; i++) arrive_a();
    chk("ar_cnt_a4", 32'(cnt_a), 32'd4);
    raw_a = 1'b1;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_cnt_a_now", 32'(cnt_a), 32'd0);
    chk("ar_Ta_now", 32'(Ta), 32'd0);
    chk("ar_cnt_b_now", 32'(cnt_b), 32'd0);
    tick(2);
    chk("ar_Ta_held", 32'(Ta), 32'd0);
    rst = 1'b1;
    tick(5);
    chk("ar_rel_Ta_e5", 32'(Ta), 32'd0);
    tick(1);
    chk("ar_rel_Ta_e6", 32'(Ta), 32'd1);
    chk("ar_rel_cnt_e6", 32'(cnt_a), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
